// File: rtl/pipe_pkg.sv
// Shared pipeline types: decode control bundle and default datapath widths.
package pipe_pkg;
   localparam int unsigned DEF_XLEN = 32;
   localparam int unsigned DEF_RA_W = 5;

   typedef struct packed {
      logic       aluSrc;
      logic       memToReg;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       branch;
      logic [1:0] aluOp;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect #(
   parameter int unsigned RA_W = pipe_pkg::DEF_RA_W
) (
   input  logic            exValid,
   input  logic            exMemRead,
   input  logic [RA_W-1:0] exRdAddr,
   input  logic            idValid,
   input  logic [RA_W-1:0] rs1Addr,
   input  logic [RA_W-1:0] rs2Addr,
   input  logic            aluSrc,
   input  logic            memWrite,
   input  logic            branch,
   input  logic            flush,
   output logic            stall
);
   logic usesRs2;
   logic rs1Match;
   logic rs2Match;
   logic hz;

   // I-type ALU ops carry an immediate in the rs2 field, so it is not a real read
   assign usesRs2  = memWrite | branch | ~aluSrc;
   assign rs1Match = (exRdAddr == rs1Addr);
   assign rs2Match = (exRdAddr == rs2Addr);
   assign hz       = exValid & exMemRead & (exRdAddr != '0) & idValid &
                     (rs1Match | (usesRs2 & rs2Match));
   assign stall    = hz & ~flush;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble injection and a saturating stall counter.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned RA_W  = DEF_RA_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid_i,
   input  logic             alu_src_i,
   input  logic             mem_to_reg_i,
   input  logic             reg_write_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic             branch_i,
   input  logic [1:0]       alu_op_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  rs1_data_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [RA_W-1:0]  rs1_addr_i,
   input  logic [RA_W-1:0]  rs2_addr_i,
   input  logic [RA_W-1:0]  rd_addr_i,
   input  logic [2:0]       funct3_i,
   input  logic             funct7b5_i,
   input  logic             flush_i,
   output logic             ex_valid_o,
   output logic             ex_alu_src_o,
   output logic             ex_mem_to_reg_o,
   output logic             ex_reg_write_o,
   output logic             ex_mem_read_o,
   output logic             ex_mem_write_o,
   output logic             ex_branch_o,
   output logic [1:0]       ex_alu_op_o,
   output logic [XLEN-1:0]  ex_pc_o,
   output logic [XLEN-1:0]  ex_rs1_data_o,
   output logic [XLEN-1:0]  ex_rs2_data_o,
   output logic [XLEN-1:0]  ex_imm_o,
   output logic [RA_W-1:0]  ex_rs1_addr_o,
   output logic [RA_W-1:0]  ex_rs2_addr_o,
   output logic [RA_W-1:0]  ex_rd_addr_o,
   output logic [2:0]       ex_funct3_o,
   output logic             ex_funct7b5_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] stall_cnt_o
);
   ctrl_t            idCtrl;
   ctrl_t            exCtrl;
   logic             exValid;
   logic [XLEN-1:0]  exPc, exRs1Data, exRs2Data, exImm;
   logic [RA_W-1:0]  exRs1Addr, exRs2Addr, exRdAddr;
   logic [2:0]       exFunct3;
   logic             exFunct7b5;
   logic             stall;
   logic [CNT_W-1:0] stallCnt;

   assign idCtrl = '{aluSrc:   alu_src_i,
                     memToReg: mem_to_reg_i,
                     regWrite: reg_write_i,
                     memRead:  mem_read_i,
                     memWrite: mem_write_i,
                     branch:   branch_i,
                     aluOp:    alu_op_i};

   hazard_detect #(.RA_W(RA_W)) uHazard (
      .exValid   (exValid),
      .exMemRead (exCtrl.memRead),
      .exRdAddr  (exRdAddr),
      .idValid   (id_valid_i),
      .rs1Addr   (rs1_addr_i),
      .rs2Addr   (rs2_addr_i),
      .aluSrc    (alu_src_i),
      .memWrite  (mem_write_i),
      .branch    (branch_i),
      .flush     (flush_i),
      .stall     (stall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush_i || stall) begin
         exValid    <= 1'b0;
         exCtrl     <= CTRL_NOP;
         exPc       <= '0;
         exRs1Data  <= '0;
         exRs2Data  <= '0;
         exImm      <= '0;
         exRs1Addr  <= '0;
         exRs2Addr  <= '0;
         exRdAddr   <= '0;
         exFunct3   <= '0;
         exFunct7b5 <= 1'b0;
      end else begin
         exValid    <= id_valid_i;
         exCtrl     <= id_valid_i ? idCtrl : CTRL_NOP;
         exPc       <= pc_i;
         exRs1Data  <= rs1_data_i;
         exRs2Data  <= rs2_data_i;
         exImm      <= imm_i;
         exRs1Addr  <= rs1_addr_i;
         exRs2Addr  <= rs2_addr_i;
         exRdAddr   <= rd_addr_i;
         exFunct3   <= funct3_i;
         exFunct7b5 <= funct7b5_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt <= '0;
      end else if (stall && (stallCnt != '1)) begin
         stallCnt <= stallCnt + CNT_W'(1);
      end
   end

   assign ex_valid_o      = exValid;
   assign ex_alu_src_o    = exCtrl.aluSrc;
   assign ex_mem_to_reg_o = exCtrl.memToReg;
   assign ex_reg_write_o  = exCtrl.regWrite;
   assign ex_mem_read_o   = exCtrl.memRead;
   assign ex_mem_write_o  = exCtrl.memWrite;
   assign ex_branch_o     = exCtrl.branch;
   assign ex_alu_op_o     = exCtrl.aluOp;
   assign ex_pc_o         = exPc;
   assign ex_rs1_data_o   = exRs1Data;
   assign ex_rs2_data_o   = exRs2Data;
   assign ex_imm_o        = exImm;
   assign ex_rs1_addr_o   = exRs1Addr;
   assign ex_rs2_addr_o   = exRs2Addr;
   assign ex_rd_addr_o    = exRdAddr;
   assign ex_funct3_o     = exFunct3;
   assign ex_funct7b5_o   = exFunct7b5;
   assign stall_o         = stall;
   assign stall_cnt_o     = stallCnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against a behavioural model of the EX slot.
module tb_id_ex_stage;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned RA_W  = 5;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic clk, rst_n;
   logic id_valid_i, alu_src_i, mem_to_reg_i, reg_write_i, mem_read_i, mem_write_i, branch_i;
   logic [1:0] alu_op_i;
   logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
   logic [RA_W-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
   logic [2:0] funct3_i;
   logic funct7b5_i, flush_i;
   logic ex_valid_o, ex_alu_src_o, ex_mem_to_reg_o, ex_reg_write_o, ex_mem_read_o;
   logic ex_mem_write_o, ex_branch_o;
   logic [1:0] ex_alu_op_o;
   logic [XLEN-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [RA_W-1:0] ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
   logic [2:0] ex_funct3_o;
   logic ex_funct7b5_o, stall_o;
   logic [CNT_W-1:0] stall_cnt_o;

   int nChecks = 0;
   int nPass   = 0;

   // Model of what the EX slot should hold; ctrl = {aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOp}
   logic            mValid;
   logic [7:0]      mCtrl;
   logic [XLEN-1:0] mPc, mRs1D, mRs2D, mImm;
   logic [RA_W-1:0] mRs1A, mRs2A, mRd;
   logic [3:0]      mFunct;
   int unsigned     mStalls;

   id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
      .alu_src_i(alu_src_i), .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .branch_i(branch_i),
      .alu_op_i(alu_op_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .imm_i(imm_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
      .funct3_i(funct3_i), .funct7b5_i(funct7b5_i), .flush_i(flush_i),
      .ex_valid_o(ex_valid_o), .ex_alu_src_o(ex_alu_src_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
      .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
      .ex_mem_write_o(ex_mem_write_o), .ex_branch_o(ex_branch_o), .ex_alu_op_o(ex_alu_op_o),
      .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
      .ex_imm_o(ex_imm_o), .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
      .ex_rd_addr_o(ex_rd_addr_o), .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o),
      .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic modelReset();
      mValid = 0; mCtrl = '0; mPc = '0; mRs1D = '0; mRs2D = '0; mImm = '0;
      mRs1A = '0; mRs2A = '0; mRd = '0; mFunct = '0; mStalls = 0;
   endtask

   // A dependent consumer of a non-x0 load currently in EX must wait, unless the branch flushes it
   function automatic logic expStall();
      logic readsRs2, loadInEx, depends;
      readsRs2 = mem_write_i || branch_i || !alu_src_i;
      loadInEx = mValid && mCtrl[4] && (mRd != 0);
      depends  = (rs1_addr_i == mRd) || (readsRs2 && (rs2_addr_i == mRd));
      return loadInEx && id_valid_i && depends && !flush_i;
   endfunction

   task automatic checkAll(input string tag);
      chk({tag, ".valid"}, 64'(ex_valid_o), 64'(mValid));
      chk({tag, ".ctrl"}, 64'({ex_alu_src_o, ex_mem_to_reg_o, ex_reg_write_o, ex_mem_read_o,
                               ex_mem_write_o, ex_branch_o, ex_alu_op_o}), 64'(mCtrl));
      chk({tag, ".pc"}, 64'(ex_pc_o), 64'(mPc));
      chk({tag, ".data"}, {ex_rs1_data_o, ex_rs2_data_o}, {mRs1D, mRs2D});
      chk({tag, ".imm"}, 64'(ex_imm_o), 64'(mImm));
      chk({tag, ".addr"}, 64'({ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o}), 64'({mRs1A, mRs2A, mRd}));
      chk({tag, ".funct"}, 64'({ex_funct3_o, ex_funct7b5_o}), 64'(mFunct));
      chk({tag, ".cnt"}, 64'(stall_cnt_o), 64'(mStalls));
   endtask

   // Called at posedge+1 with ID inputs already driven; returns at the next posedge+1
   task automatic cycle(input string tag);
      logic s;
      #4;
      s = expStall();
      chk({tag, ".stall"}, 64'(stall_o), 64'(s));
      @(posedge clk);
      if (flush_i || s) begin
         mValid = 0; mCtrl = '0; mPc = '0; mRs1D = '0; mRs2D = '0; mImm = '0;
         mRs1A = '0; mRs2A = '0; mRd = '0; mFunct = '0;
      end else begin
         mValid = id_valid_i;
         mCtrl  = id_valid_i ? {alu_src_i, mem_to_reg_i, reg_write_i, mem_read_i,
                                mem_write_i, branch_i, alu_op_i} : 8'h00;
         mPc = pc_i; mRs1D = rs1_data_i; mRs2D = rs2_data_i; mImm = imm_i;
         mRs1A = rs1_addr_i; mRs2A = rs2_addr_i; mRd = rd_addr_i;
         mFunct = {funct3_i, funct7b5_i};
      end
      if (s && mStalls < CNT_MAX) mStalls++;
      #1;
      checkAll(tag);
   endtask

   task automatic randomId();
      id_valid_i = ($urandom_range(0, 7) != 0);
      alu_src_i = 1'($urandom); mem_to_reg_i = 1'($urandom); reg_write_i = 1'($urandom);
      mem_read_i = 1'($urandom); mem_write_i = 1'($urandom); branch_i = 1'($urandom);
      alu_op_i = 2'($urandom);
      pc_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
      rs1_addr_i = RA_W'($urandom_range(0, 3)); rs2_addr_i = RA_W'($urandom_range(0, 3));
      rd_addr_i = RA_W'($urandom_range(0, 3));
      funct3_i = 3'($urandom); funct7b5_i = 1'($urandom);
      flush_i = ($urandom_range(0, 9) == 0);
   endtask

   // Instruction helper: {aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOp}
   task automatic instr(input logic [7:0] c, input int unsigned rs1, input int unsigned rs2,
                        input int unsigned rd, input logic [2:0] f3);
      id_valid_i = 1;
      {alu_src_i, mem_to_reg_i, reg_write_i, mem_read_i, mem_write_i, branch_i, alu_op_i} = c;
      rs1_addr_i = RA_W'(rs1); rs2_addr_i = RA_W'(rs2); rd_addr_i = RA_W'(rd);
      funct3_i = f3; funct7b5_i = 0; flush_i = 0;
      pc_i = pc_i + 4; rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
   endtask

   localparam logic [7:0] C_ADD  = 8'b0010_0010;
   localparam logic [7:0] C_ADDI = 8'b1010_0010;
   localparam logic [7:0] C_LW   = 8'b1111_0000;
   localparam logic [7:0] C_SW   = 8'b1000_1000;

   initial begin
      rst_n = 0;
      randomId();
      id_valid_i = 1; flush_i = 0;
      modelReset();
      @(posedge clk); @(posedge clk); #1;
      checkAll("reset");
      rst_n = 1;
      #1;
      checkAll("post_release");
      pc_i = 32'h100;

      instr(C_ADD, 1, 2, 3, 3'b000);
      cycle("add");
      chk("add.rd", 64'(ex_rd_addr_o), 64'd3);
      chk("add.rw_valid", 64'({ex_reg_write_o, ex_valid_o}), 64'b11);

      instr(C_LW, 1, 0, 5, 3'b010);
      cycle("lw5");
      instr(C_ADD, 5, 1, 6, 3'b000);
      cycle("use_stall");
      chk("use_stall.bubble", 64'(ex_valid_o), 64'd0);
      cycle("use_release");
      chk("use_release.rd", 64'(ex_rd_addr_o), 64'd6);
      chk("use_release.cnt", 64'(stall_cnt_o), 64'd1);

      instr(C_LW, 1, 0, 0, 3'b010);
      cycle("lw0");
      instr(C_ADD, 0, 1, 6, 3'b000);
      cycle("lw0_use");
      chk("lw0_use.valid", 64'(ex_valid_o), 64'd1);

      instr(C_LW, 1, 0, 5, 3'b010);
      cycle("lw5b");
      instr(C_ADDI, 7, 5, 6, 3'b000);
      cycle("addi_nostall");
      chk("addi_nostall.valid", 64'(ex_valid_o), 64'd1);

      instr(C_LW, 1, 0, 5, 3'b010);
      cycle("lw5c");
      instr(C_SW, 2, 5, 0, 3'b010);
      flush_i = 1;
      cycle("flush_sw");
      chk("flush_sw.bubble", 64'(ex_valid_o), 64'd0);
      chk("flush_sw.cnt", 64'(stall_cnt_o), 64'd1);

      for (int i = 0; i < 600; i++) begin
         randomId();
         cycle("rand");
      end
      chk("cnt_saturated", 64'(stall_cnt_o), 64'(CNT_MAX));

      instr(C_LW, 1, 0, 5, 3'b010);
      cycle("lw5d");
      instr(C_ADD, 5, 1, 6, 3'b000);
      #2;
      chk("midstall.stall", 64'(stall_o), 64'd1);
      rst_n = 0;
      #1;
      modelReset();
      chk("midstall_reset.stall", 64'(stall_o), 64'd0);
      checkAll("midstall_reset");
      rst_n = 1;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for the RISC-V pipeline. It registers the control bundle produced by the decode control unit, together with the decoded operands, into the EX stage. It also detects load-use hazards against the instruction currently in EX and injects a bubble when one occurs. On a taken-branch flush from EX it squashes the instruction it would otherwise capture.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- CNT_W, 16, width of the stall event counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID holds a real instruction
- alu_src_i, mem_to_reg_i, reg_write_i, mem_read_i, mem_write_i, branch_i  in  1 each  control bundle from decode
- alu_op_i  in  2  ALU op class from decode
- pc_i  in  XLEN  PC of the ID instruction
- rs1_data_i, rs2_data_i, imm_i  in  XLEN  register-file reads and sign-extended immediate
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  RA_W  register specifiers
- funct3_i  in  3  instruction funct3
- funct7b5_i  in  1  instruction bit 30 (add/sub select)
- flush_i  in  1  taken branch resolved in EX; squash ID
- ex_valid_o  out  1  EX holds a real instruction
- ex_alu_src_o, ex_mem_to_reg_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o  out  1 each  registered control
- ex_alu_op_o  out  2  registered ALU op
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN  registered operands
- ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  RA_W  registered specifiers
- ex_funct3_o  out  3  registered funct3
- ex_funct7b5_o  out  1  registered funct7 bit 5
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- stall_cnt_o  out  CNT_W  saturating count of load-use stalls

## Operation
- Hazard term: hz = ex_valid_o & ex_mem_read_o & (ex_rd_addr_o != 0) & id_valid_i & (rs1 match | (uses_rs2 & rs2 match)).
- rs1 match is ex_rd_addr_o == rs1_addr_i; rs2 match is ex_rd_addr_o == rs2_addr_i.
- uses_rs2 = mem_write_i | branch_i | ~alu_src_i.
- stall_o = hz & ~flush_i.
- The register updates every cycle with the following priority:
  1. flush_i = 1: load a bubble.
  2. stall_o = 1: load a bubble.
  3. Otherwise: capture all ID inputs, with ex_valid_o <= id_valid_i.
- Bubble: ex_valid_o and all control and ALU-op outputs are 0, and every data, address and funct field is 0.
- If id_valid_i = 0, the control outputs are captured as 0, whatever their input values.
- stall_cnt_o increments by 1 on every cycle with stall_o = 1 and saturates at 2^CNT_W-1, with no wrap.
- A load followed by a dependent instruction gives exactly one stall cycle. On the next cycle the bubble occupies EX, so hz = 0.

## Timing
- Every registered output has a latency of 1 clock from its inputs.
- stall_o is combinational from the current EX contents and the ID inputs, with zero latency.
- Reset is asynchronous, with every output and stall_cnt_o = 0. The stage therefore comes out of reset holding a bubble.
- Reset asserted mid-stall clears the stall immediately.
- flush_i and hz in the same cycle: the flush wins, stall_o = 0, a bubble is loaded, and the counter does not increment.
- rd = x0 as the load destination never stalls.
- A load whose rd matches rs2 of a consumer with uses_rs2 = 0 (an I-type ALU op) does not stall.

## Structure
- Shared package pipe_pkg:
  - ctrl_t packed struct covering the six control bits plus alu_op.
  - CTRL_NOP constant, all zeros.
  - XLEN and RA_W defaults.
- Sub-module hazard_detect contains the purely combinational hz/stall_o logic. The register and the counter stay in id_ex_stage.

## Test plan
- Reset with the ID inputs busy -> all outputs 0 and stall_cnt_o = 0 until the first edge after rst_n rises.
- ADD x3,x1,x2 (reg_write = 1, alu_op = 10, funct3 = 000), id_valid_i = 1 -> the next cycle shows ex_rd_addr_o = 3, ex_reg_write_o = 1, ex_valid_o = 1 and stall_o = 0.
- LW x5 in EX, then ADD x6,x5,x1 in ID -> stall_o = 1 for one cycle, the next cycle EX holds a bubble, then ADD is captured; stall_cnt_o = 1.
- LW x0 in EX, then ADD x6,x0,x1 in ID -> stall_o = 0 and no bubble.
- LW x5 in EX, then ADDI x6,x7,x5-field (alu_src = 1, rs2_addr = 5) -> stall_o = 0.
- LW x5 in EX, dependent SW x5 in ID, and flush_i = 1 -> stall_o = 0, a bubble is loaded, and stall_cnt_o is unchanged.
